// File: rtl/hangman_pkg.sv
// rtl/hangman_pkg.sv - shared types and constants for the message TX arbiter
package hangman_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    DONE = 3'd3,
    GAP  = 3'd4
  } tx_arb_state_t;

  localparam logic SRC_HOST   = 1'b0;
  localparam logic SRC_PLAYER = 1'b1;

  localparam logic [3:0] SYNC_NIBBLE_DEFAULT = 4'hA;

  // Header byte: sync nibble on top, source id in bit 0
  function automatic logic [7:0] make_header(input logic [3:0] sync, input logic src);
    return {sync, 3'b000, src};
  endfunction

endpackage

// File: rtl/msg_tx_arbiter_rr_arb2.sv
// rtl/msg_tx_arbiter_rr_arb2.sv - two-way round-robin grant with registered pointer
module rr_arb2
  import hangman_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       ptr_en,
  input  logic       ptr_src,
  output logic       gnt_valid,
  output logic       gnt_src
);

  logic ptr_q;
  logic ptr_d;

  // Grant: on a tie the side that did not win last time goes first
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_src = ~ptr_q;
    end else begin
      gnt_src = req[1];
    end
    ptr_d = ptr_en ? ptr_src : ptr_q;
  end

  // Pointer remembers the source of the last completed frame; player after reset so host wins first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= SRC_PLAYER;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/msg_tx_arbiter.sv
// rtl/msg_tx_arbiter.sv - frames host/player characters into header+payload bytes for the UART
module msg_tx_arbiter
  import hangman_pkg::*;
#(
  parameter int         GAP_CYCLES  = 4,
  parameter logic [3:0] SYNC_NIBBLE = SYNC_NIBBLE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_req,
  input  logic [7:0] host_data,
  output logic       host_ack,
  input  logic       player_req,
  input  logic [7:0] player_data,
  output logic       player_ack,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       msg_sent,
  output logic       busy,
  output logic       last_src
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  tx_arb_state_t    state_q, state_d;
  logic             src_q, src_d;
  logic [7:0]       data_q, data_d;
  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             host_ack_q, host_ack_d;
  logic             player_ack_q, player_ack_d;
  logic             msg_sent_q, msg_sent_d;
  logic             busy_q, busy_d;
  logic             last_src_q, last_src_d;

  logic gnt_valid;
  logic gnt_src;
  logic ptr_en;
  logic accept;

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req       ({player_req, host_req}),
    .ptr_en    (ptr_en),
    .ptr_src   (src_q),
    .gnt_valid (gnt_valid),
    .gnt_src   (gnt_src)
  );

  assign accept = tx_valid_q && tx_ready;

  // Next-state and next-output logic for the framing sequence
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    host_ack_d   = 1'b0;
    player_ack_d = 1'b0;
    msg_sent_d   = 1'b0;
    last_src_d   = last_src_q;
    ptr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d    = HDR;
          src_d      = gnt_src;
          data_d     = (gnt_src == SRC_HOST) ? host_data : player_data;
          tx_valid_d = 1'b1;
          tx_data_d  = make_header(SYNC_NIBBLE, gnt_src);
        end
      end
      HDR: begin
        if (accept) begin
          state_d   = PAY;
          tx_data_d = data_q;
        end
      end
      PAY: begin
        if (accept) begin
          state_d      = DONE;
          tx_valid_d   = 1'b0;
          tx_data_d    = 8'h00;
          host_ack_d   = (src_q == SRC_HOST);
          player_ack_d = (src_q == SRC_PLAYER);
          msg_sent_d   = 1'b1;
          last_src_d   = src_q;
          ptr_en       = 1'b1;
        end
      end
      DONE: begin
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset aborts any frame in flight without an ack
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      src_q        <= SRC_HOST;
      data_q       <= 8'h00;
      cnt_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      host_ack_q   <= 1'b0;
      player_ack_q <= 1'b0;
      msg_sent_q   <= 1'b0;
      busy_q       <= 1'b0;
      last_src_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      host_ack_q   <= host_ack_d;
      player_ack_q <= player_ack_d;
      msg_sent_q   <= msg_sent_d;
      busy_q       <= busy_d;
      last_src_q   <= last_src_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign host_ack   = host_ack_q;
  assign player_ack = player_ack_q;
  assign msg_sent   = msg_sent_q;
  assign busy       = busy_q;
  assign last_src   = last_src_q;

endmodule

// File: tb/tb_msg_tx_arbiter.sv
// tb/tb_msg_tx_arbiter.sv - bench for msg_tx_arbiter against a frame-level reference model
module tb_msg_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // gap-4 instance
  logic rst = 1'b1, host_req = 1'b0, player_req = 1'b0, tx_ready = 1'b0;
  logic [7:0] host_data = 8'h00, player_data = 8'h00;
  logic host_ack, player_ack, tx_valid, msg_sent, busy, last_src;
  logic [7:0] tx_data;

  // gap-0 instance
  logic rst_z = 1'b1, host_req_z = 1'b0, player_req_z = 1'b0, tx_ready_z = 1'b0;
  logic [7:0] host_data_z = 8'h00, player_data_z = 8'h00;
  logic host_ack_z, player_ack_z, tx_valid_z, msg_sent_z, busy_z, last_src_z;
  logic [7:0] tx_data_z;

  msg_tx_arbiter #(.GAP_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_data(host_data), .host_ack(host_ack),
    .player_req(player_req), .player_data(player_data), .player_ack(player_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .msg_sent(msg_sent), .busy(busy), .last_src(last_src)
  );

  msg_tx_arbiter #(.GAP_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst_z),
    .host_req(host_req_z), .host_data(host_data_z), .host_ack(host_ack_z),
    .player_req(player_req_z), .player_data(player_data_z), .player_ack(player_ack_z),
    .tx_valid(tx_valid_z), .tx_data(tx_data_z), .tx_ready(tx_ready_z),
    .msg_sent(msg_sent_z), .busy(busy_z), .last_src(last_src_z)
  );

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  // Frame-level model: bytes still to send, quiet cycles left (DONE + gap), last-winner pointer
  typedef struct {
    int         nb;
    logic [7:0] hdr;
    logic [7:0] pay;
    logic       src;
    int         quiet;
    logic       ptr;
    logic       ls;
    logic       ha;
    logic       pa;
  } mstate_t;

  function automatic mstate_t mstep(mstate_t s, logic r, logic hr, logic [7:0] hd,
                                    logic pr, logic [7:0] pd, logic rdy, int gap);
    mstate_t n = s;
    logic g;
    n.ha = 1'b0;
    n.pa = 1'b0;
    if (r) begin
      n.nb = 0; n.hdr = 8'h00; n.pay = 8'h00; n.src = 1'b0;
      n.quiet = 0; n.ptr = 1'b1; n.ls = 1'b0;
      return n;
    end
    if (s.nb > 0) begin
      if (rdy) begin
        n.nb = s.nb - 1;
        if (n.nb == 0) begin
          n.ha = ~s.src;
          n.pa = s.src;
          n.ls = s.src;
          n.ptr = s.src;
          n.quiet = 1 + gap;
        end
      end
    end else if (s.quiet > 0) begin
      n.quiet = s.quiet - 1;
    end else if (hr || pr) begin
      g = (hr && pr) ? ~s.ptr : pr;
      n.src = g;
      n.nb = 2;
      n.hdr = {4'hA, 3'b000, g};
      n.pay = g ? pd : hd;
    end
    return n;
  endfunction

  function automatic logic [13:0] mout(mstate_t s);
    logic [7:0] d;
    d = (s.nb == 2) ? s.hdr : ((s.nb == 1) ? s.pay : 8'h00);
    return {s.nb > 0, d, s.ha, s.pa, s.ha | s.pa, (s.nb > 0) || (s.quiet > 0), s.ls};
  endfunction

  // tx_data is only meaningful while tx_valid is high
  function automatic logic [13:0] mask(logic [13:0] o);
    logic [13:0] m = o;
    if (!m[13]) m[12:5] = 8'h00;
    return m;
  endfunction

  task automatic cmp(string name, logic [13:0] act, logic [13:0] exp);
    vectors++;
    if (mask(act) !== mask(exp)) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got v/d/ha/pa/ms/busy/ls=%h want %h", name, cycle, mask(act), mask(exp));
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cycle, act, exp);
    end
  endtask

  mstate_t ms_a, ms_z;
  logic chk_a = 1'b0, chk_z = 1'b0;

  always @(posedge clk) begin
    ms_a = mstep(ms_a, rst, host_req, host_data, player_req, player_data, tx_ready, 4);
    ms_z = mstep(ms_z, rst_z, host_req_z, host_data_z, player_req_z, player_data_z, tx_ready_z, 0);
  end

  always @(negedge clk) begin
    if (chk_a) cmp("model_gap4", {tx_valid, tx_data, host_ack, player_ack, msg_sent, busy, last_src}, mout(ms_a));
    if (chk_z) cmp("model_gap0", {tx_valid_z, tx_data_z, host_ack_z, player_ack_z, msg_sent_z, busy_z, last_src_z}, mout(ms_z));
  end

  typedef struct {
    logic       r;
    logic       hr;
    logic [7:0] hd;
    logic       pr;
    logic [7:0] pd;
    logic       rdy;
    logic [13:0] exp;
  } vec_t;

  function automatic vec_t mk(logic r, logic hr, logic [7:0] hd, logic pr, logic [7:0] pd, logic rdy,
                              logic ev, logic [7:0] ed, logic eha, logic epa, logic ems, logic eb, logic els);
    vec_t v;
    v.r = r; v.hr = hr; v.hd = hd; v.pr = pr; v.pd = pd; v.rdy = rdy;
    v.exp = {ev, ed, eha, epa, ems, eb, els};
    return v;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_idle_timeout @cycle %0d: busy stuck at 1, need 0", cycle);
    end
  endtask

  vec_t tbl[$];
  logic       v6[12];
  logic [7:0] d6[12];
  logic       a6[12];
  int         lows;

  initial begin
    // Test 1: single host frame; rows list inputs for a cycle and the outputs seen the cycle after
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h41, 0, 8'h00, 1,  1, 8'hA0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h41, 0, 8'h00, 1,  1, 8'h41, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h41, 0, 8'h00, 1,  0, 8'h00, 1, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 8'h41, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h41, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0, 0));
    // Test 2: simultaneous requests after reset, host wins, player follows after the gap
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h50, 1, 8'h48, 1,  1, 8'hA0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h50, 1, 8'h48, 1,  1, 8'h50, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h50, 1, 8'h48, 1,  0, 8'h00, 1, 0, 1, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 8'h50, 1, 8'h48, 1,  0, 8'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h50, 1, 8'h48, 1,  0, 8'h00, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h50, 1, 8'h48, 1,  1, 8'hA1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h50, 1, 8'h48, 1,  1, 8'h48, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h50, 1, 8'h48, 1,  0, 8'h00, 0, 1, 1, 1, 1));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 8'h50, 0, 8'h48, 1,  0, 8'h00, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h50, 0, 8'h48, 1,  0, 8'h00, 0, 0, 0, 0, 1));

    @(negedge clk);
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i > 0) begin
        chk_a = 1'b1;
        cmp($sformatf("table_row%0d", i - 1),
            {tx_valid, tx_data, host_ack, player_ack, msg_sent, busy, last_src}, tbl[i - 1].exp);
      end
      if (i < tbl.size()) begin
        rst = tbl[i].r; host_req = tbl[i].hr; host_data = tbl[i].hd;
        player_req = tbl[i].pr; player_data = tbl[i].pd; tx_ready = tbl[i].rdy;
        rst_z = tbl[i].r;
        if (i == 0) chk_z = 1'b1;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    rst_z = 1'b0;

    // Test 3: header held while tx_ready is low for 10 cycles, accepted on the 11th
    wait_idle();
    player_req = 1'b1; player_data = 8'h52; tx_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("t3_hdr_hold", {20'h0, tx_valid, tx_data, player_ack, msg_sent}, {20'h0, 1'b1, 8'hA1, 1'b0, 1'b0});
      if (i == 10) tx_ready = 1'b1;
    end
    @(negedge clk);
    chk("t3_payload", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h52});
    @(negedge clk);
    chk("t3_ack", {30'h0, player_ack, msg_sent}, {30'h0, 1'b1, 1'b1});
    player_req = 1'b0;

    // Test 4: data change after grant does not reach the payload
    wait_idle();
    player_req = 1'b1; player_data = 8'h45; tx_ready = 1'b1;
    @(negedge clk);
    player_data = 8'h4C;
    @(negedge clk);
    chk("t4_latched_payload", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h45});
    @(negedge clk);
    chk("t4_ack", {31'h0, player_ack}, 32'h1);
    player_req = 1'b0;

    // Test 5: reset during PAY aborts, next host request frames normally
    wait_idle();
    host_req = 1'b1; host_data = 8'h77; tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_abort", {28'h0, tx_valid, busy, host_ack, msg_sent}, 32'h0);
    rst = 1'b0; host_data = 8'h5A;
    @(negedge clk);
    chk("t5_hdr_after_rst", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hA0});
    @(negedge clk);
    chk("t5_pay_after_rst", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'h5A});
    @(negedge clk);
    chk("t5_ack_after_rst", {31'h0, host_ack}, 32'h1);
    host_req = 1'b0;

    // Randomized traffic on the gap-4 instance, checked by the model every cycle
    wait_idle();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 399) == 0);
      tx_ready = ($urandom_range(0, 9) < 7);
      if (host_req && host_ack) host_req = ($urandom_range(0, 4) == 0);
      else if (!host_req) host_req = ($urandom_range(0, 3) == 0);
      if (player_req && player_ack) player_req = ($urandom_range(0, 4) == 0);
      else if (!player_req) player_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) host_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) player_data = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; host_req = 1'b0; player_req = 1'b0; tx_ready = 1'b1;
    wait_idle();

    // Test 6: gap-0 instance with host_req held, frames back to back through DONE and IDLE
    rst_z = 1'b1;
    @(negedge clk);
    rst_z = 1'b0; host_req_z = 1'b1; host_data_z = 8'h33; tx_ready_z = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      v6[i] = tx_valid_z; d6[i] = tx_data_z; a6[i] = host_ack_z;
    end
    host_req_z = 1'b0;
    chk("t6_hdr0", {23'h0, v6[0], d6[0]}, {23'h0, 1'b1, 8'hA0});
    chk("t6_pay0", {23'h0, v6[1], d6[1]}, {23'h0, 1'b1, 8'h33});
    lows = 0;
    for (int i = 2; i < 12 && !v6[i]; i++) lows++;
    chk("t6_low_cycles", lows, 2);
    chk("t6_hdr1", {23'h0, v6[4], d6[4]}, {23'h0, 1'b1, 8'hA0});
    chk("t6_acks", {29'h0, a6[2], a6[3], a6[6]}, {29'h0, 3'b101});
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
